// File: rtl/seq_mac_pkg.sv
// rtl/seq_mac_pkg.sv - shared types and defaults for the sequential MAC controller
//
// Contents:
//   state_t           controller FSM states
//   DEF_OP_W          default operand width (matches the 6x6 multiplier)
//   DEF_ACC_W         default accumulator width
//   DEF_MULT_LAT      default multiplier latency in cycles after the load edge
//   cnt_width()       width of a counter that must hold 0..lat-1
package seq_mac_pkg;

    localparam int DEF_OP_W     = 6;
    localparam int DEF_ACC_W    = 16;
    localparam int DEF_MULT_LAT = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_RUN,
        S_ACC,
        S_OUT
    } state_t;

    // At least one bit, even for a latency of 1.
    function automatic int cnt_width(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/seq_mac_ctrl.sv
// rtl/seq_mac_ctrl.sv - sequencer and accumulator around a 6x6 sequential multiplier
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand pair handshake; in_a, in_b operands, in_last closes the sum
//   mult_rst, mult_load      one-cycle control pulses to the multiplier
//   mult_a, mult_b           registered operands held stable for the multiplier
//   mult_product             multiplier result, final MULT_LAT cycles after the load edge
//   out_valid/out_ready      sum handshake; out_sum accumulated sum, out_ovf sticky wrap flag
module seq_mac_ctrl
    import seq_mac_pkg::*;
#(
    parameter int OP_W     = DEF_OP_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_a,
    input  logic [OP_W-1:0]     in_b,
    input  logic                in_last,
    output logic                mult_rst,
    output logic                mult_load,
    output logic [OP_W-1:0]     mult_a,
    output logic [OP_W-1:0]     mult_b,
    input  logic [2*OP_W-1:0]   mult_product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_sum,
    output logic                out_ovf
);

    localparam int CW = cnt_width(MULT_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MULT_LAT - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             last_q;
    logic [ACC_W:0]   sum_ext;

    // One extra bit on top of the accumulator captures the carry-out of the add.
    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - 2*OP_W){1'b0}}, mult_product};

    // The accumulator only moves in ACC and on the output handshake,
    // so it doubles as the held output value while a sum is pending.
    assign out_sum = acc;
    assign out_ovf = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            mult_rst  <= 1'b0;
            mult_load <= 1'b0;
            mult_a    <= '0;
            mult_b    <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // in_ready is always high here, so in_valid alone is the handshake.
                    if (in_valid) begin
                        mult_a   <= in_a;
                        mult_b   <= in_b;
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        mult_rst <= 1'b1;
                        state    <= S_CLR;
                    end
                end
                S_CLR: begin
                    // The multiplier keeps residue from the previous pair; it is
                    // cleared before every load.
                    mult_rst  <= 1'b0;
                    mult_load <= 1'b1;
                    state     <= S_LOAD;
                end
                S_LOAD: begin
                    mult_load <= 1'b0;
                    cnt       <= '0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_ACC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACC: begin
                    acc <= sum_ext[ACC_W-1:0];
                    ovf <= ovf | sum_ext[ACC_W];
                    if (last_q) begin
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
